// File: rtl/mult4_pkg.sv
// Shared constants, state encoding and pin indices for the sequential 4x4 multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: N/PROD_W/CNT_W widths, state_t enum, uio bit indices, uio_oe constant.
package mult4_pkg;

  localparam int N      = 4;
  localparam int PROD_W = 2 * N;
  localparam int CNT_W  = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int START_BIT = 0;
  localparam int BUSY_BIT  = 1;
  localparam int DONE_BIT  = 2;

  localparam logic [7:0] UIO_OE_VAL = 8'h06;

endpackage

// File: rtl/mult4_shift_add_dp.sv
// Shift-add datapath: operand, accumulator and step-counter registers for one multiply.
// Latency: load on one edge, then W step edges; result is combinational on the last step.
// Backpressure: none; the controller drives load/step and samples result when last is high.
// Ports: clk, rst_n; load/step controls; a_in/b_in operands; result (sum after current step); last.
// Macro MULT4_SIGNED_EN: two's-complement operands, top partial product subtracted.
module mult4_shift_add_dp #(
  parameter int W  = 4,
  parameter int PW = 2 * W,
  parameter int CW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic [W-1:0]  a_in,
  input  logic [W-1:0]  b_in,
  output logic [PW-1:0] result,
  output logic          last
);

  logic [PW-1:0] a;
  logic [W-1:0]  b;
  logic [PW-1:0] acc;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pp;
  logic [PW-1:0] a_ext;

  // Multiplicand is widened once at load so every step is a plain shift.
`ifdef MULT4_SIGNED_EN
  assign a_ext = {{W{a_in[W-1]}}, a_in};
`else
  assign a_ext = {{W{1'b0}}, a_in};
`endif

  assign last = (cnt == CW'(W - 1));

  always_comb begin
    pp = '0;
    if (b[0]) pp = a << cnt;
`ifdef MULT4_SIGNED_EN
    // The multiplier's sign bit carries weight -2^(W-1).
    result = last ? (acc - pp) : (acc + pp);
`else
    result = acc + pp;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a   <= '0;
      b   <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (load) begin
      a   <= a_ext;
      b   <= b_in;
      acc <= '0;
      cnt <= '0;
    end else if (step) begin
      acc <= result;
      b   <= b >> 1;
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/tt_um_mult_4_seq.sv
// TinyTapeout tile: sequential shift-add 4x4 multiplier with start/busy/done handshake.
// Latency: launch at edge k, product and done pulse after edge k+4, IDLE again after k+5.
// Backpressure: none; start edges seen while busy or done are dropped, not queued.
// Ports: clk, rst_n, ena; ui_in = {B, A}; uo_out = registered product;
//        uio_in[0] = start; uio_out[1] = busy, uio_out[2] = done; uio_oe constant 8'h06.
// Macro MULT4_SIGNED_EN: operands and product are two's complement.
module tt_um_mult_4_seq
  import mult4_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t            state;
  state_t            state_nxt;
  logic              start_q;
  logic              launch;
  logic              load;
  logic              step;
  logic              busy;
  logic              done;
  logic              last;
  logic [PROD_W-1:0] result;
  logic              unused_pins;

  assign unused_pins = &{1'b0, uio_in[7:1]};

  // Rising-edge detect: holding start high launches only once.
  assign launch = ena & uio_in[START_BIT] & ~start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) start_q <= 1'b0;
    else        start_q <= uio_in[START_BIT];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (launch) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  mult4_shift_add_dp #(
    .W (N)
  ) u_dp (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .step   (step),
    .a_in   (ui_in[N-1:0]),
    .b_in   (ui_in[2*N-1:N]),
    .result (result),
    .last   (last)
  );

  // Product register only moves on the completion edge, so it holds between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            uo_out <= '0;
    else if (step && last) uo_out <= result;
  end

  always_comb begin
    uio_out           = '0;
    uio_out[BUSY_BIT] = busy;
    uio_out[DONE_BIT] = done;
  end

  assign uio_oe = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_mult_4_seq.sv
module tb_tt_um_mult_4_seq;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic busy_pin;
  logic done_pin;
  assign busy_pin = uio_out[1];
  assign done_pin = uio_out[2];

  int pass_cnt = 0;
  int chk_cnt  = 0;

  tt_um_mult_4_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the arithmetic product of the operands, truncated to 8 bits.
  function automatic logic [7:0] ref_prod(input logic [3:0] a, input logic [3:0] b);
    int p;
`ifdef MULT4_SIGNED_EN
    p = int'($signed(a)) * int'($signed(b));
`else
    p = int'(a) * int'(b);
`endif
    return p[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation: raise start, drop it after launch, scramble ui_in while running,
  // wait (bounded) for done, then step into IDLE so the next call is back-to-back.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                       output logic [7:0] res, output int lat,
                       output logic held, output logic done_after);
    logic [7:0] prev;
    prev      = uo_out;
    held      = 1'b1;
    ui_in     = {b, a};
    uio_in[0] = 1'b1;
    lat       = 0;
    do begin
      tick();
      lat++;
      uio_in[0] = 1'b0;
      ui_in     = 8'($urandom);
      if (!done_pin && uo_out !== prev) held = 1'b0;
    end while (!done_pin && lat < 20);
    res = uo_out;
    tick();
    done_after = done_pin;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    tick();
    tick();
    chk_cnt++;
    if (uo_out !== 8'h00) $display("FAIL reset_uo_out got=%h exp=00", uo_out);
    else pass_cnt++;
    chk_cnt++;
    if (uio_out !== 8'h00) $display("FAIL reset_uio_out got=%h exp=00", uio_out);
    else pass_cnt++;
    chk_cnt++;
    if (uio_oe !== 8'h06) $display("FAIL reset_uio_oe got=%h exp=06", uio_oe);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
    chk_cnt++;
    if (uio_out !== 8'h00) $display("FAIL post_reset_idle got=%h exp=00", uio_out);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [7:0] exp;
    exp       = ref_prod(4'd7, 4'd3);
    ui_in     = {4'd3, 4'd7};
    uio_in[0] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      uio_in[0] = 1'b0;
      chk_cnt++;
      if (busy_pin !== 1'b1 || done_pin !== 1'b0)
        $display("FAIL basic_busy cycle=%0d got busy=%b done=%b exp busy=1 done=0", j, busy_pin, done_pin);
      else pass_cnt++;
    end
    tick();
    chk_cnt++;
    if (done_pin !== 1'b1 || busy_pin !== 1'b0 || uo_out !== exp)
      $display("FAIL basic_done got done=%b busy=%b uo=%h exp done=1 busy=0 uo=%h", done_pin, busy_pin, uo_out, exp);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (done_pin !== 1'b0 || busy_pin !== 1'b0 || uo_out !== exp)
      $display("FAIL basic_idle got done=%b busy=%b uo=%h exp done=0 busy=0 uo=%h", done_pin, busy_pin, uo_out, exp);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] res;
    int         lat;
    logic       held;
    logic       dn;
    int         bad = 0;
    for (int i = 0; i < 256; i++) begin
      do_op(i[3:0], i[7:4], res, lat, held, dn);
      chk_cnt++;
      if (res !== ref_prod(i[3:0], i[7:4]) || lat != 5 || dn !== 1'b0) begin
        $display("FAIL sweep a=%0d b=%0d got=%h lat=%0d done_after=%b exp=%h lat=5 done_after=0",
                 i[3:0], i[7:4], res, lat, dn, ref_prod(i[3:0], i[7:4]));
        bad++;
      end else pass_cnt++;
      chk_cnt++;
      if (!held) $display("FAIL sweep_hold a=%0d b=%0d uo_out moved before done", i[3:0], i[7:4]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [3:0] a, b;
    logic [7:0] res;
    int         lat;
    logic       held;
    logic       dn;
    for (int i = 0; i < 40; i++) begin
      a = 4'($urandom);
      b = 4'($urandom);
      do_op(a, b, res, lat, held, dn);
      chk_cnt++;
      if (res !== ref_prod(a, b) || !held)
        $display("FAIL random a=%0d b=%0d got=%h held=%b exp=%h held=1", a, b, res, held, ref_prod(a, b));
      else pass_cnt++;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic test_hold_start();
    int dones = 0;
    int busy_after = 0;
    ui_in     = {4'd5, 4'd9};
    uio_in[0] = 1'b1;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (done_pin) dones++;
    end
    uio_in[0] = 1'b0;
    tick();
    chk_cnt++;
    if (dones != 1) $display("FAIL hold_start_dones got=%0d exp=1", dones);
    else pass_cnt++;
    chk_cnt++;
    if (uo_out !== ref_prod(4'd9, 4'd5)) $display("FAIL hold_start_result got=%h exp=%h", uo_out, ref_prod(4'd9, 4'd5));
    else pass_cnt++;

    // Second start edge while running, with new operands, must be dropped.
    dones     = 0;
    ui_in     = {4'd5, 4'd3};
    uio_in[0] = 1'b1;
    tick();
    uio_in[0] = 1'b0;
    tick();
    ui_in     = {4'd13, 4'd11};
    uio_in[0] = 1'b1;
    tick();
    uio_in[0] = 1'b0;
    for (int j = 0; j < 12; j++) begin
      tick();
      if (done_pin) dones++;
      if (j > 4 && busy_pin) busy_after++;
    end
    chk_cnt++;
    if (dones != 1 || busy_after != 0)
      $display("FAIL mid_run_start got dones=%0d late_busy=%0d exp dones=1 late_busy=0", dones, busy_after);
    else pass_cnt++;
    chk_cnt++;
    if (uo_out !== ref_prod(4'd3, 4'd5)) $display("FAIL mid_run_result got=%h exp=%h", uo_out, ref_prod(4'd3, 4'd5));
    else pass_cnt++;
  endtask

  task automatic test_ena();
    logic [7:0] prev;
    int         saw = 0;
    int         cyc = 0;
    logic [7:0] exp;
    prev      = uo_out;
    ena       = 1'b0;
    ui_in     = {4'd6, 4'd6};
    uio_in[0] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (busy_pin || done_pin) saw++;
    end
    uio_in[0] = 1'b0;
    tick();
    chk_cnt++;
    if (saw != 0 || uo_out !== prev)
      $display("FAIL ena_low got activity=%0d uo=%h exp activity=0 uo=%h", saw, uo_out, prev);
    else pass_cnt++;

    // Dropping ena mid-run must not abort.
    ena       = 1'b1;
    exp       = ref_prod(4'd12, 4'd10);
    ui_in     = {4'd10, 4'd12};
    uio_in[0] = 1'b1;
    tick();
    uio_in[0] = 1'b0;
    tick();
    ena = 1'b0;
    while (!done_pin && cyc < 20) begin
      tick();
      cyc++;
    end
    chk_cnt++;
    if (!done_pin || uo_out !== exp)
      $display("FAIL ena_drop got done=%b uo=%h exp done=1 uo=%h", done_pin, uo_out, exp);
    else pass_cnt++;
    ena = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] res;
    int         lat;
    logic       held;
    logic       dn;
    int         dones = 0;
    do_op(4'd5, 4'd6, res, lat, held, dn);
    chk_cnt++;
    if (res !== ref_prod(4'd5, 4'd6)) $display("FAIL pre_reset_op got=%h exp=%h", res, ref_prod(4'd5, 4'd6));
    else pass_cnt++;
    ui_in     = {4'd15, 4'd15};
    uio_in[0] = 1'b1;
    tick();
    uio_in[0] = 1'b0;
    tick();
    tick();
    chk_cnt++;
    if (busy_pin !== 1'b1) $display("FAIL reset_mid_busy_before got=%b exp=1", busy_pin);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (uo_out !== 8'h00 || busy_pin !== 1'b0)
      $display("FAIL reset_mid_immediate got uo=%h busy=%b exp uo=00 busy=0", uo_out, busy_pin);
    else pass_cnt++;
    for (int j = 0; j < 3; j++) begin
      tick();
      if (done_pin) dones++;
    end
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick();
      if (done_pin || busy_pin) dones++;
    end
    chk_cnt++;
    if (dones != 0) $display("FAIL reset_mid_no_done got=%0d exp=0", dones);
    else pass_cnt++;
    do_op(4'd14, 4'd11, res, lat, held, dn);
    chk_cnt++;
    if (res !== ref_prod(4'd14, 4'd11) || lat != 5)
      $display("FAIL post_reset_op got=%h lat=%0d exp=%h lat=5", res, lat, ref_prod(4'd14, 4'd11));
    else pass_cnt++;
  endtask

`ifdef MULT4_SIGNED_EN
  task automatic test_signed();
    logic [7:0] res;
    int         lat;
    logic       held;
    logic       dn;
    do_op(4'h8, 4'h8, res, lat, held, dn);
    chk_cnt++;
    if (res !== 8'h40) $display("FAIL signed_m8_m8 got=%h exp=40", res);
    else pass_cnt++;
    do_op(4'hF, 4'h7, res, lat, held, dn);
    chk_cnt++;
    if (res !== 8'hF9) $display("FAIL signed_m1_7 got=%h exp=F9", res);
    else pass_cnt++;
    do_op(4'h7, 4'h8, res, lat, held, dn);
    chk_cnt++;
    if (res !== 8'hC8) $display("FAIL signed_7_m8 got=%h exp=C8", res);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_random();
    test_hold_start();
    test_ena();
    test_reset_mid_run();
`ifdef MULT4_SIGNED_EN
    test_signed();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
